// File: rtl/tlul_host_rr_arb_if.sv
// tlul_host_rr_arb_if: TL-UL request/response types and the bus bundle between hosts, arbiter and crossbar.
package tlul_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;
  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

interface tlul_host_rr_arb_if import tlul_pkg::*; #(parameter int M = 2);
  tl_h2d_t [M-1:0] tl_h_i;
  tl_d2h_t [M-1:0] tl_h_o;
  tl_h2d_t         tl_d_o;
  tl_d2h_t         tl_d_i;
  modport slave (input tl_h_i, tl_d_i, output tl_h_o, tl_d_o);
  modport master (output tl_h_i, tl_d_i, input tl_h_o, tl_d_o);
endinterface

// File: rtl/tlul_host_rr_arb.sv
// tlul_host_rr_arb: M:1 TL-UL host arbiter, round-robin with grant lock and an in-order ID FIFO for response routing.
module tlul_host_rr_arb import tlul_pkg::*; #(
  parameter int M = 2,
  parameter int Depth = 4,
  localparam int IdxW = (M > 1) ? $clog2(M) : 1,
  localparam int CntW = $clog2(Depth + 1),
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  tlul_host_rr_arb_if.slave bus,
  output logic [CntW-1:0] outstanding_o,
  output logic            busy_o,
  output logic            err_o
);
  logic [IdxW-1:0] rr_q, rr_d, lidx_q, lidx_d, sel, head;
  logic            lock_q, lock_d, err_q, err_d;
  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] mem_q [Depth];
  logic            full, empty, av, hs, dr, pop;
  assign full  = cnt_q == CntW'(Depth);
  assign empty = cnt_q == '0;
  assign head  = mem_q[rd_q];
  // Descending scan so the host nearest rr_q wins.
  always_comb begin
    sel = rr_q;
    for (int i = M - 1; i >= 0; i--)
      if (bus.tl_h_i[IdxW'((int'(rr_q) + i) % M)].a_valid) sel = IdxW'((int'(rr_q) + i) % M);
    if (lock_q) sel = lidx_q;
  end
  assign av  = rst_ni & ~full & bus.tl_h_i[sel].a_valid;
  assign hs  = av & bus.tl_d_i.a_ready;
  assign dr  = rst_ni & (empty | bus.tl_h_i[head].d_ready);
  assign pop = ~empty & bus.tl_d_i.d_valid & dr;
  always_comb begin
    bus.tl_d_o = bus.tl_h_i[sel];
    bus.tl_d_o.a_valid = av;
    bus.tl_d_o.d_ready = dr;
    for (int i = 0; i < M; i++) begin
      bus.tl_h_o[i] = bus.tl_d_i;
      bus.tl_h_o[i].a_ready = rst_ni & ~full & bus.tl_d_i.a_ready & (sel == IdxW'(i));
      bus.tl_h_o[i].d_valid = rst_ni & ~empty & bus.tl_d_i.d_valid & (head == IdxW'(i));
    end
  end
  always_comb begin
    rr_d   = hs ? IdxW'((int'(sel) + 1) % M) : rr_q;
    lock_d = hs ? 1'b0 : (av ? 1'b1 : lock_q);
    lidx_d = (av & ~hs) ? sel : lidx_q;
    wr_d   = hs ? ((wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d   = pop ? ((rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d  = (hs & ~pop) ? cnt_q + 1'b1 : (pop & ~hs) ? cnt_q - 1'b1 : cnt_q;
    err_d  = err_q | (empty & bus.tl_d_i.d_valid);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q   <= '0;
      lock_q <= 1'b0;
      lidx_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      lock_q <= lock_d;
      lidx_q <= lidx_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end
  always_ff @(posedge clk_i) if (hs) mem_q[wr_q] <= sel;
  assign outstanding_o = cnt_q;
  assign busy_o        = (cnt_q != '0) | lock_q;
  assign err_o         = err_q;
endmodule

// File: tb/tb_tlul_host_rr_arb.sv
// tb_tlul_host_rr_arb: directed self-checking bench for the TL-UL host arbiter (M=2, Depth=4).
module tb_tlul_host_rr_arb;
  import tlul_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] outstanding;
  logic       busy, err;
  int         checks = 0;
  int         errors = 0;
  tlul_host_rr_arb_if #(.M(2)) bus ();
  tlul_host_rr_arb #(.M(2), .Depth(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus.slave),
    .outstanding_o(outstanding), .busy_o(busy), .err_o(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Advance one edge, settle, and confirm occupancy never exceeds Depth.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("cnt_range", 64'(outstanding <= 3'd4), 64'd1);
  endtask
  initial begin
    bus.tl_h_i = '0;
    bus.tl_d_i = '0;
    bus.tl_h_i[0].a_valid = 1'b1;
    bus.tl_d_i.a_ready = 1'b1;
    tick();
    tick();
    chk("rst_out", 64'(outstanding), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_av", 64'(bus.tl_d_o.a_valid), 64'd0);
    chk("rst_dr", 64'(bus.tl_d_o.d_ready), 64'd0);
    chk("rst_ar0", 64'(bus.tl_h_o[0].a_ready), 64'd0);
    bus.tl_h_i[0].a_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("idle_dr", 64'(bus.tl_d_o.d_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    // host0 alone: three back-to-back Gets
    bus.tl_h_i[0].a_valid = 1'b1;
    bus.tl_h_i[0].a_address = 32'h100;
    #1;
    chk("t1_av", 64'(bus.tl_d_o.a_valid), 64'd1);
    chk("t1_addr", 64'(bus.tl_d_o.a_address), 64'h100);
    chk("t1_ar0", 64'(bus.tl_h_o[0].a_ready), 64'd1);
    chk("t1_ar1", 64'(bus.tl_h_o[1].a_ready), 64'd0);
    tick();
    bus.tl_h_i[0].a_address = 32'h104;
    #1;
    chk("t1_addr2", 64'(bus.tl_d_o.a_address), 64'h104);
    tick();
    bus.tl_h_i[0].a_address = 32'h108;
    tick();
    bus.tl_h_i[0].a_valid = 1'b0;
    chk("t1_peak", 64'(outstanding), 64'd3);
    bus.tl_d_i.d_valid = 1'b1;
    bus.tl_d_i.d_data = 32'hA0;
    bus.tl_h_i[0].d_ready = 1'b1;
    #1;
    chk("t1_dv0", 64'(bus.tl_h_o[0].d_valid), 64'd1);
    chk("t1_dv1", 64'(bus.tl_h_o[1].d_valid), 64'd0);
    chk("t1_data", 64'(bus.tl_h_o[0].d_data), 64'hA0);
    chk("t1_dr", 64'(bus.tl_d_o.d_ready), 64'd1);
    tick();
    chk("t1_out2", 64'(outstanding), 64'd2);
    chk("t1_dv0b", 64'(bus.tl_h_o[0].d_valid), 64'd1);
    tick();
    tick();
    bus.tl_d_i.d_valid = 1'b0;
    chk("t1_out0", 64'(outstanding), 64'd0);
    // both hosts continuously valid: rr_ptr is 1 here, grants go 1,0,1,0
    bus.tl_h_i[0].a_source = 8'h10;
    bus.tl_h_i[1].a_source = 8'h11;
    bus.tl_h_i[1].d_ready = 1'b1;
    bus.tl_h_i[0].a_valid = 1'b1;
    bus.tl_h_i[1].a_valid = 1'b1;
    #1;
    chk("t2_g0", 64'(bus.tl_d_o.a_source), 64'h11);
    chk("t2_ar1", 64'(bus.tl_h_o[1].a_ready), 64'd1);
    tick();
    bus.tl_d_i.d_valid = 1'b1;
    for (int k = 1; k < 4; k++) begin
      #1;
      chk("t2_grant", 64'(bus.tl_d_o.a_source), (k % 2 == 1) ? 64'h10 : 64'h11);
      tick();
      chk("t2_cnt", 64'(outstanding), 64'd1);
    end
    bus.tl_h_i[0].a_valid = 1'b0;
    bus.tl_h_i[1].a_valid = 1'b0;
    tick();
    bus.tl_d_i.d_valid = 1'b0;
    chk("t2_out0", 64'(outstanding), 64'd0);
    chk("t2_err", 64'(err), 64'd0);
    // lock: host1 stalled by a_ready=0, host0 joins mid-stall
    bus.tl_d_i.a_ready = 1'b0;
    bus.tl_h_i[1].a_valid = 1'b1;
    bus.tl_h_i[1].a_address = 32'h200;
    bus.tl_h_i[0].a_address = 32'h300;
    #1;
    chk("t3_addr", 64'(bus.tl_d_o.a_address), 64'h200);
    chk("t3_ar1", 64'(bus.tl_h_o[1].a_ready), 64'd0);
    tick();
    bus.tl_h_i[0].a_valid = 1'b1;
    #1;
    chk("t3_lock_addr", 64'(bus.tl_d_o.a_address), 64'h200);
    chk("t3_busy", 64'(busy), 64'd1);
    tick();
    chk("t3_lock_addr2", 64'(bus.tl_d_o.a_address), 64'h200);
    tick();
    bus.tl_d_i.a_ready = 1'b1;
    #1;
    chk("t3_hs_addr", 64'(bus.tl_d_o.a_address), 64'h200);
    chk("t3_hs_ar1", 64'(bus.tl_h_o[1].a_ready), 64'd1);
    chk("t3_hs_ar0", 64'(bus.tl_h_o[0].a_ready), 64'd0);
    tick();
    bus.tl_h_i[1].a_valid = 1'b0;
    #1;
    chk("t3_next", 64'(bus.tl_d_o.a_address), 64'h300);
    chk("t3_next_ar0", 64'(bus.tl_h_o[0].a_ready), 64'd1);
    tick();
    bus.tl_h_i[0].a_valid = 1'b0;
    bus.tl_d_i.d_valid = 1'b1;
    #1;
    chk("t3_rsp1", 64'(bus.tl_h_o[1].d_valid), 64'd1);
    chk("t3_rsp1_0", 64'(bus.tl_h_o[0].d_valid), 64'd0);
    tick();
    chk("t3_rsp0", 64'(bus.tl_h_o[0].d_valid), 64'd1);
    tick();
    bus.tl_d_i.d_valid = 1'b0;
    chk("t3_out0", 64'(outstanding), 64'd0);
    // fill to Depth with no responses; the 5th request waits for a pop
    bus.tl_h_i[0].a_valid = 1'b1;
    bus.tl_h_i[0].a_address = 32'h400;
    repeat (4) tick();
    chk("t4_full", 64'(outstanding), 64'd4);
    chk("t4_av", 64'(bus.tl_d_o.a_valid), 64'd0);
    chk("t4_ar0", 64'(bus.tl_h_o[0].a_ready), 64'd0);
    bus.tl_d_i.d_valid = 1'b1;
    #1;
    chk("t4_av_pop", 64'(bus.tl_d_o.a_valid), 64'd0);
    tick();
    bus.tl_d_i.d_valid = 1'b0;
    chk("t4_out3", 64'(outstanding), 64'd3);
    chk("t4_av5", 64'(bus.tl_d_o.a_valid), 64'd1);
    tick();
    bus.tl_h_i[0].a_valid = 1'b0;
    chk("t4_refill", 64'(outstanding), 64'd4);
    bus.tl_d_i.d_valid = 1'b1;
    repeat (4) tick();
    bus.tl_d_i.d_valid = 1'b0;
    chk("t4_out0", 64'(outstanding), 64'd0);
    // interleaved host0, host1, host0 with host1 stalling its response
    bus.tl_h_i[0].a_valid = 1'b1;
    tick();
    bus.tl_h_i[0].a_valid = 1'b0;
    bus.tl_h_i[1].a_valid = 1'b1;
    tick();
    bus.tl_h_i[1].a_valid = 1'b0;
    bus.tl_h_i[0].a_valid = 1'b1;
    tick();
    bus.tl_h_i[0].a_valid = 1'b0;
    chk("t5_out3", 64'(outstanding), 64'd3);
    bus.tl_h_i[1].d_ready = 1'b0;
    bus.tl_d_i.d_valid = 1'b1;
    bus.tl_d_i.d_data = 32'hD0;
    #1;
    chk("t5_r0", 64'(bus.tl_h_o[0].d_valid), 64'd1);
    tick();
    chk("t5_r1", 64'(bus.tl_h_o[1].d_valid), 64'd1);
    chk("t5_r1_0", 64'(bus.tl_h_o[0].d_valid), 64'd0);
    chk("t5_stall", 64'(bus.tl_d_o.d_ready), 64'd0);
    tick();
    chk("t5_held", 64'(outstanding), 64'd2);
    bus.tl_h_i[1].d_ready = 1'b1;
    #1;
    chk("t5_go", 64'(bus.tl_d_o.d_ready), 64'd1);
    tick();
    chk("t5_r2", 64'(bus.tl_h_o[0].d_valid), 64'd1);
    tick();
    bus.tl_d_i.d_valid = 1'b0;
    chk("t5_out0", 64'(outstanding), 64'd0);
    // reset with two outstanding, then a stray response
    bus.tl_h_i[0].a_valid = 1'b1;
    tick();
    tick();
    bus.tl_h_i[0].a_valid = 1'b0;
    chk("t6_out2", 64'(outstanding), 64'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("t6_out0", 64'(outstanding), 64'd0);
    chk("t6_err0", 64'(err), 64'd0);
    bus.tl_d_i.d_valid = 1'b1;
    #1;
    chk("t6_drain", 64'(bus.tl_d_o.d_ready), 64'd1);
    chk("t6_dv0", 64'(bus.tl_h_o[0].d_valid), 64'd0);
    tick();
    bus.tl_d_i.d_valid = 1'b0;
    chk("t6_err", 64'(err), 64'd1);
    tick();
    chk("t6_sticky", 64'(err), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("t6_errclr", 64'(err), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tlul_host_rr_arb.md
Name: tlul_host_rr_arb

Overview:
- M:1 TileLink-UL host arbiter that shares one upstream bus between the masters in front of the crossbar.
- Arbitration is round-robin with a grant lock: a granted A-channel request is held until it is accepted downstream.
- The arbiter records which host issued each accepted request in an in-order ID FIFO, and uses it to route D-channel responses back.
- It sits between the CPU/DMA host ports and the crossbar's single downstream host input. It provides outstanding-transaction accounting and protocol-error detection.

Parameters:
- M, 2, number of hosts (M >= 2).
- Depth, 4, maximum outstanding transactions; this is the ID FIFO depth (Depth >= 1).
- IdxW, $clog2(M), host index width (derived, not overridable).
- CntW, $clog2(Depth+1), outstanding counter width (derived).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; synchronous, active-low.
- tl_h_i  input  tl_h2d_t[M]  host A-channel requests and d_ready.
- tl_h_o  output  tl_d2h_t[M]  per-host a_ready and routed D-channel responses.
- tl_d_o  output  tl_h2d_t  muxed request towards the crossbar.
- tl_d_i  input  tl_d2h_t  crossbar response.
- outstanding_o  output  CntW  current FIFO occupancy.
- busy_o  output  1  high when outstanding_o != 0 or the lock is held.
- err_o  output  1  sticky flag: a D response arrived with the FIFO empty.

Behaviour:
- Reset (synchronous, rst_ni low at a clk_i edge):
  - rr_ptr=0, lock=0, locked_idx=0, FIFO empty, err_o=0.
  - All outputs go to their quiescent values: tl_d_o.a_valid=0, tl_d_o.d_ready=0, every tl_h_o.a_ready=0, every tl_h_o.d_valid=0.
  - Reset mid-transaction discards FIFO contents. Responses arriving afterwards are handled by the FIFO-empty rule below.
- Arbitration (combinational):
  - If lock=1, sel=locked_idx.
  - Otherwise sel is the first host with a_valid=1, scanning rr_ptr, rr_ptr+1, ... wrapping modulo M.
  - If no host has a_valid=1, sel=rr_ptr and tl_d_o.a_valid=0.
- A path:
  - tl_d_o carries all A fields of tl_h_i[sel] unmodified, except tl_d_o.a_valid = tl_h_i[sel].a_valid & ~full.
  - tl_h_o[sel].a_ready = tl_d_i.a_ready & ~full. Every other host sees a_ready=0.
  - Zero added latency.
- Lock:
  - lock<=1 and locked_idx<=sel when tl_d_o.a_valid=1 and tl_d_i.a_ready=0.
  - lock<=0 on an A handshake.
  - This guarantees the TL-UL rule that an asserted valid is not withdrawn and its request does not change.
- On A handshake (tl_d_o.a_valid & tl_d_i.a_ready):
  - Push sel into the FIFO.
  - rr_ptr <= (sel+1) mod M.
  - With no handshake, rr_ptr holds.
- full = (count==Depth), computed from registered state only.
  - A push is refused when full, even if a pop happens in the same cycle; that request is accepted one cycle later.
- D path, FIFO non-empty, head index h:
  - tl_h_o[h] D fields = tl_d_i D fields, including d_valid.
  - Every other host sees d_valid=0.
  - tl_d_o.d_ready = tl_h_i[h].d_ready.
  - Pop on D handshake.
- D path, FIFO empty:
  - tl_d_o.d_ready=1, so a stray response is drained.
  - No host sees d_valid.
  - If tl_d_i.d_valid=1, set err_o=1; it clears only on reset.
- Counter update: push and pop in the same cycle leave count unchanged; push only gives count+1; pop only gives count-1.
  - Underflow and overflow are impossible by construction, and the bench must assert this.
- The FIFO is a circular buffer with wr/rd pointers wrapping at Depth, so Depth need not be a power of two.
- outstanding_o=count, registered.

Test Plan:
- Only host0 issues 3 back-to-back Gets; downstream a_ready=1, responses returned 2 cycles later -> host0 gets all 3 d_valid, host1 sees none, outstanding_o peaks at 3 and returns to 0.
- Hosts 0 and 1 both hold a_valid continuously, a_ready=1 -> grants alternate 0,1,0,1; rr_ptr advances by 1 per handshake.
- Host1 granted while a_ready=0 for 4 cycles and host0 raises a_valid in cycle 2 -> tl_d_o stays on host1 with unchanged address until the handshake; host0 is granted on the next cycle.
- Depth=4, a_ready=1, d_valid held 0 -> 4 requests accepted, then a_valid on tl_d_o drops to 0 with full=1. Pop one response -> the 5th request is accepted the following cycle, not the same cycle.
- Interleaved requests host0, host1, host0, with responses returned in order -> each response arrives at the matching host. Holding host1 d_ready=0 while its response is at the FIFO head stalls tl_d_o.d_ready.
- Pulse rst_ni low for 1 cycle with 2 outstanding, then inject d_valid=1 -> outstanding_o=0 after reset, the response is drained with d_ready=1, and err_o=1 stays set until the next reset.
